// File: rtl/trace_buffer_if.sv
// Capture and readout channels of the trace buffer, grouped as one bus.
// No logic inside; it only bundles wires.
// Readout uses valid/ready. Capture has no backpressure: the strobe is always taken or dropped.
interface trace_buffer_if #(
    parameter int XLEN = 64
);
    logic            cap_valid;
    logic [XLEN-1:0] cap_pc;
    logic [31:0]     cap_instr;
    logic [XLEN-1:0] cap_result;
    logic            rd_ready;
    logic            rd_valid;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_instr;
    logic [XLEN-1:0] rd_result;

    // The agent side drives captures and accepts the readout.
    modport master (
        output cap_valid, cap_pc, cap_instr, cap_result, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_result
    );

    // The trace buffer side consumes captures and presents the head entry.
    modport slave (
        input  cap_valid, cap_pc, cap_instr, cap_result, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_result
    );
endinterface

// File: rtl/trace_buffer.sv
// Instruction trace buffer: a circular capture ring with arm/trigger/freeze control and in-order drain.
// Latency: a capture is stored one edge after the strobe. The head entry is presented combinationally.
// Backpressure: the readout holds the head while rd_ready=0. A capture into a full ring overwrites the oldest entry or is dropped.
module trace_buffer #(
    parameter int XLEN     = 64,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic                       mode_wrap,
    trace_buffer_if.slave              bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [1:0]                 state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] POST_LIM = CW'(POST_CNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_POST    = 2'b10,
        ST_FROZEN  = 2'b11
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] result;
    } entry_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_cnt_q, post_cnt_d;
    logic            overflow_q, overflow_d;
    logic            mode_q, mode_d;

    entry_t          mem_q [DEPTH];
    entry_t          wr_dat;
    logic            wr_en;
    logic            capturing;
    logic            pop;
    logic            rd_vld;

    // Captures are live only while recording. An arm in the same cycle wins and discards the capture.
    assign capturing = bus.cap_valid && !arm &&
                       ((state_q == ST_CAPTURE) || (state_q == ST_POST));
    assign pop       = rd_vld && bus.rd_ready && !arm;
    assign wr_dat    = '{pc: bus.cap_pc, instr: bus.cap_instr, result: bus.cap_result};

    // State register. A synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Arm restarts from any state. A trigger counts only in CAPTURE.
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_CAPTURE;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (trigger) begin
                        state_d = (POST_CNT == 0) ? ST_FROZEN : ST_POST;
                    end
                end
                ST_POST: begin
                    if (bus.cap_valid && (post_cnt_q + 1'b1 == POST_LIM)) begin
                        state_d = ST_FROZEN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs decoded from state. The ring may be drained only when it is not recording.
    always_comb begin
        rd_vld = 1'b0;
        if ((state_q == ST_IDLE) || (state_q == ST_FROZEN)) begin
            rd_vld = (count_q != '0);
        end
    end

    // Ring bookkeeping: pointers, occupancy, post-trigger count, sticky overflow and latched wrap mode.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        overflow_d = overflow_q;
        mode_d     = mode_q;
        wr_en      = 1'b0;
        if (arm) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            overflow_d = 1'b0;
            mode_d     = mode_wrap;
        end else begin
            if (capturing) begin
                if (count_q == FULL_CNT) begin
                    overflow_d = 1'b1;
                    if (mode_q) begin
                        // When full, the write slot is the head, so both pointers advance together.
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end
                if (state_q == ST_POST) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                end
            end
            // A pop never coincides with a capture because readout is gated off while recording.
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
        end
    end

    // Control flops, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            overflow_q <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            overflow_q <= overflow_d;
            mode_q     <= mode_d;
        end
    end

    // Entry storage is a plain register array. Its contents are meaningless until written, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

    assign bus.rd_valid  = rd_vld;
    assign bus.rd_pc     = mem_q[rd_ptr_q].pc;
    assign bus.rd_instr  = mem_q[rd_ptr_q].instr;
    assign bus.rd_result = mem_q[rd_ptr_q].result;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign state         = state_q;
endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: capture scenarios with a scoreboard of expected entries.
// Inputs change 1ns after a rising edge, and outputs are sampled there, away from the edge.
// The readout is drained with rd_ready and compared in order against the scoreboard.
module tb_trace_buffer;
    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int PCNT  = 4;

    logic       clk = 1'b0;
    logic       rst, arm, trigger, mode_wrap;
    logic [4:0] count;
    logic       overflow;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    // Reference model: the queue of entries the ring should hold, oldest first.
    logic [63:0] sb [$];
    int          m_state;
    bit          m_wrap;
    int          m_post;

    trace_buffer_if #(.XLEN(XLEN)) bus ();

    trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_CNT(PCNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .trigger   (trigger),
        .mode_wrap (mode_wrap),
        .bus       (bus),
        .count     (count),
        .overflow  (overflow),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h5A5A_0000;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        sb.delete();
        m_state = 0;
        m_post = 0;
        m_wrap = 1'b0;
    endtask

    task automatic do_arm(input bit wrap);
        arm = 1'b1;
        mode_wrap = wrap;
        cyc();
        arm = 1'b0;
        mode_wrap = 1'b0;
        sb.delete();
        m_state = 1;
        m_post = 0;
        m_wrap = wrap;
    endtask

    task automatic do_trig();
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        if (m_state == 1) m_state = (PCNT == 0) ? 3 : 2;
    endtask

    task automatic do_cap(input logic [63:0] pc);
        bus.cap_valid  = 1'b1;
        bus.cap_pc     = pc;
        bus.cap_instr  = instr_of(pc);
        bus.cap_result = ~pc;
        cyc();
        bus.cap_valid  = 1'b0;
        if (m_state == 1 || m_state == 2) begin
            if (sb.size() == DEPTH) begin
                if (m_wrap) begin
                    void'(sb.pop_front());
                    sb.push_back(pc);
                end
            end else begin
                sb.push_back(pc);
            end
            if (m_state == 2) begin
                m_post++;
                if (m_post == PCNT) m_state = 3;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b1; trigger = 1'b1; bus.cap_valid = 1'b1; bus.rd_ready = 1'b1;
        cyc();
        arm = 1'b0; trigger = 1'b0; bus.cap_valid = 1'b0; bus.rd_ready = 1'b0;
        do_reset();
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rdv: got %0b want 0", bus.rd_valid); end
        do_cap(64'h55);
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL idle_cap_ignored: count got %0d want 0", count); end
    endtask

    task automatic test_basic();
        logic [63:0] exp;
        int n;
        do_arm(1'b0);
        for (int i = 0; i < 5; i++) do_cap(64'h100 + 64'(4 * i));
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL capture_rdv: got %0b want 0", bus.rd_valid); end
        do_trig();
        tests++; if (state !== 2'b10) begin fails++; $display("FAIL basic_post: state got %0d want 2", state); end
        for (int i = 5; i < 9; i++) do_cap(64'h100 + 64'(4 * i));
        tests++; if (state !== 2'b11) begin fails++; $display("FAIL basic_frozen: state got %0d want 3", state); end
        do_cap(64'h999);
        tests++; if (count !== 5'd9) begin fails++; $display("FAIL basic_count: got %0d want 9", count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %0b want 0", overflow); end
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            exp = sb.pop_front();
            tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp || bus.rd_instr !== instr_of(exp) || bus.rd_result !== ~exp) begin
                fails++; $display("FAIL basic_drain[%0d]: got v=%0b pc=%h want pc=%h", i, bus.rd_valid, bus.rd_pc, exp);
            end
            bus.rd_ready = 1'b1; cyc(); bus.rd_ready = 1'b0;
        end
        tests++; if (bus.rd_valid !== 1'b0 || count !== 5'd0) begin fails++; $display("FAIL basic_empty: v=%0b count=%0d want 0/0", bus.rd_valid, count); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp;
        int n;
        do_arm(1'b1);
        for (int i = 1; i <= 20; i++) do_cap(64'(i));
        do_trig();
        for (int i = 21; i <= 24; i++) do_cap(64'(i));
        tests++; if (state !== 2'b11) begin fails++; $display("FAIL wrap_frozen: state got %0d want 3", state); end
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL wrap_count: got %0d want 16", count); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL wrap_ovf: got %0b want 1", overflow); end
        tests++; if (bus.rd_pc !== 64'd9) begin fails++; $display("FAIL wrap_first: got %0d want 9", bus.rd_pc); end
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            exp = sb.pop_front();
            tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp || bus.rd_result !== ~exp) begin
                fails++; $display("FAIL wrap_drain[%0d]: got v=%0b pc=%0d want pc=%0d", i, bus.rd_valid, bus.rd_pc, exp);
            end
            if (i == n - 1) begin
                tests++; if (bus.rd_pc !== 64'd24) begin fails++; $display("FAIL wrap_last: got %0d want 24", bus.rd_pc); end
            end
            bus.rd_ready = 1'b1; cyc(); bus.rd_ready = 1'b0;
        end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL wrap_empty: count got %0d want 0", count); end
    endtask

    task automatic test_drop();
        logic [63:0] exp;
        int n;
        do_arm(1'b0);
        for (int i = 1; i <= 20; i++) do_cap(64'(i));
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL drop_count: got %0d want 16", count); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL drop_ovf: got %0b want 1", overflow); end
        do_trig();
        for (int i = 21; i <= 24; i++) do_cap(64'(i));
        tests++; if (state !== 2'b11 || count !== 5'd16) begin fails++; $display("FAIL drop_frozen: state=%0d count=%0d want 3/16", state, count); end
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            exp = sb.pop_front();
            tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp) begin
                fails++; $display("FAIL drop_drain[%0d]: got v=%0b pc=%0d want pc=%0d", i, bus.rd_valid, bus.rd_pc, exp);
            end
            bus.rd_ready = 1'b1; cyc(); bus.rd_ready = 1'b0;
        end
        do_arm(1'b0);
        tests++; if (state !== 2'b01 || count !== 5'd0 || overflow !== 1'b0) begin
            fails++; $display("FAIL rearm_clear: state=%0d count=%0d ovf=%0b want 1/0/0", state, count, overflow);
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp;
        do_arm(1'b0);
        for (int i = 0; i < 3; i++) do_cap(64'h200 + 64'(i));
        do_trig();
        for (int i = 3; i < 7; i++) do_cap(64'h200 + 64'(i));
        for (int i = 0; i < 4; i++) begin
            exp = sb.pop_front();
            tests++; if (bus.rd_pc !== exp) begin fails++; $display("FAIL stall_pre[%0d]: got %h want %h", i, bus.rd_pc, exp); end
            bus.rd_ready = 1'b1; cyc(); bus.rd_ready = 1'b0;
        end
        tests++; if (count !== 5'd3) begin fails++; $display("FAIL stall_count: got %0d want 3", count); end
        exp = sb[0];
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp || bus.rd_instr !== instr_of(exp)) begin
                fails++; $display("FAIL stall_hold[%0d]: got v=%0b pc=%h want pc=%h", i, bus.rd_valid, bus.rd_pc, exp);
            end
            cyc();
        end
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = sb.pop_front();
            tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_pc !== exp) begin
                fails++; $display("FAIL stall_pop[%0d]: got v=%0b pc=%h want pc=%h", i, bus.rd_valid, bus.rd_pc, exp);
            end
            cyc();
        end
        bus.rd_ready = 1'b0;
        tests++; if (bus.rd_valid !== 1'b0 || count !== 5'd0) begin fails++; $display("FAIL stall_empty: v=%0b count=%0d want 0/0", bus.rd_valid, count); end
    endtask

    task automatic test_arm_trigger();
        do_reset();
        do_trig();
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL idle_trigger: state got %0d want 0", state); end
        arm = 1'b1; trigger = 1'b1;
        cyc();
        arm = 1'b0; trigger = 1'b0;
        tests++; if (state !== 2'b01) begin fails++; $display("FAIL arm_trigger: state got %0d want 1", state); end
        m_state = 1; sb.delete();
    endtask

    task automatic test_rst_post();
        do_arm(1'b1);
        for (int i = 0; i < 5; i++) do_cap(64'h300 + 64'(i));
        do_trig();
        do_cap(64'h305);
        do_cap(64'h306);
        tests++; if (state !== 2'b10 || count !== 5'd7) begin fails++; $display("FAIL rst_pre: state=%0d count=%0d want 2/7", state, count); end
        rst = 1'b1; arm = 1'b1; trigger = 1'b1; bus.cap_valid = 1'b1; bus.rd_ready = 1'b1;
        cyc();
        rst = 1'b0; arm = 1'b0; trigger = 1'b0; bus.cap_valid = 1'b0; bus.rd_ready = 1'b0;
        tests++; if (state !== 2'b00 || count !== 5'd0 || overflow !== 1'b0 || bus.rd_valid !== 1'b0) begin
            fails++; $display("FAIL rst_post: state=%0d count=%0d ovf=%0b v=%0b want 0/0/0/0", state, count, overflow, bus.rd_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; arm = 1'b0; trigger = 1'b0; mode_wrap = 1'b0;
        bus.cap_valid = 1'b0; bus.cap_pc = '0; bus.cap_instr = '0; bus.cap_result = '0; bus.rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_drop();
        test_stall();
        test_arm_trigger();
        test_rst_post();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
